// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first, one bit per clk with a registered borrow between slices.
// Optional signed-overflow output Ovf is built when SERIAL_SUB_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | one bit slice per cycle, WIDTH cycles
// DONE  | one-cycle done pulse, results already registered
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] rr;
   logic             bin;
   logic [CW-1:0]    cnt;
   logic             a_bit;
   logic             b_bit;
   logic             d;
   logic             bout;
   logic [WIDTH-1:0] rr_next;
`ifdef SERIAL_SUB_OVF_EN
   logic             sa;
   logic             sb;
`endif

   assign a_bit   = ra[0];
   assign b_bit   = rb[0];
   assign d       = a_bit ^ b_bit ^ bin;
   assign bout    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
   assign rr_next = {d, rr[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ra     <= '0;
         rb     <= '0;
         rr     <= '0;
         bin    <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         Diff   <= '0;
         Borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         sa     <= 1'b0;
         sb     <= 1'b0;
         Ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ra    <= A;
                  rb    <= B;
                  bin   <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                  // sign bits are shifted out of ra/rb, so keep them aside
                  sa    <= A[WIDTH-1];
                  sb    <= B[WIDTH-1];
`endif
               end
            end
            SHIFT: begin
               bin <= bout;
               ra  <= {1'b0, ra[WIDTH-1:1]};
               rb  <= {1'b0, rb[WIDTH-1:1]};
               rr  <= rr_next;
               if (cnt == CNT_LAST) begin
                  Diff   <= rr_next;
                  Borrow <= bout;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                  Ovf    <= (sa ^ sb) & (sa ^ d);
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: hand-computed vectors, start masking,
// mid-operation reset and back-to-back re-acceptance with start held high.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Diff;
   logic             Borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic             Ovf;
`endif

   int n_cmp;
   int n_bad;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .done   (done),
      .Diff   (Diff),
      .Borrow (Borrow)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .Ovf    (Ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called #1 after a posedge; that next posedge is E0.
   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_diff, input logic exp_borrow, input logic exp_ovf);
      int lat;
      int busy_cnt;
      bit seen;
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      A        = ~a;
      B        = ~b;
      busy_cnt = busy ? 1 : 0;
      lat      = 0;
      seen     = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) seen = 1'b1;
         else if (busy) busy_cnt++;
      end
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      chk({tag, " latency"}, 32'(lat), 32'd8);
      chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd8);
      chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, " diff"}, 32'(Diff), 32'(exp_diff));
      chk({tag, " borrow"}, 32'(Borrow), 32'(exp_borrow));
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, " ovf"}, 32'(Ovf), 32'(exp_ovf));
`else
      if (exp_ovf) begin end
`endif
      @(posedge clk);
      #1;
      chk({tag, " done_clear"}, 32'(done), 32'd0);
      chk({tag, " diff_hold"}, 32'(Diff), 32'(exp_diff));
   endtask

   initial begin
      int pulses;
      int k1;
      int k2;
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      #12;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst diff", 32'(Diff), 32'd0);
      chk("rst borrow", 32'(Borrow), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      do_op("v35_12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
      do_op("v12_35", 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
      do_op("v00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      do_op("v00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
      do_op("v80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      do_op("v7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
      do_op("v05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

      // second start during SHIFT must be ignored
      A = 8'h10; B = 8'h01; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      pulses = 0;
      for (int i = 1; i <= 14; i++) begin
         if (i == 3) begin A = 8'hFF; B = 8'h00; start = 1'b1; end
         if (i == 4) start = 1'b0;
         @(posedge clk);
         #1;
         if (i == 2) begin A = 8'hFF; B = 8'h00; start = 1'b1; end
         if (i == 3) start = 1'b0;
         if (done) pulses++;
      end
      chk("ign pulses", 32'(pulses), 32'd1);
      chk("ign diff", 32'(Diff), 32'h0F);
      chk("ign borrow", 32'(Borrow), 32'd0);

      // reset in the middle of an operation
      A = 8'hAA; B = 8'h55; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mrst busy", 32'(busy), 32'd0);
      chk("mrst done", 32'(done), 32'd0);
      chk("mrst diff", 32'(Diff), 32'd0);
      chk("mrst borrow", 32'(Borrow), 32'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      chk("mrst pulses", 32'(pulses), 32'd0);
      rst_n = 1'b1;
      do_op("v09_0a", 8'h09, 8'h0A, 8'hFF, 1'b1, 1'b0);

      // start held high: re-accepted every WIDTH+2 cycles
      A = 8'h40; B = 8'h20; start = 1'b1;
      pulses = 0;
      k1 = -1;
      k2 = -1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulses++;
            if (pulses == 1) k1 = k;
            if (pulses == 2) k2 = k;
         end
         if (k == 13) chk("held diff_between", 32'(Diff), 32'h20);
      end
      start = 1'b0;
      chk("held first_pulse", 32'(k1), 32'd8);
      chk("held second_pulse", 32'(k2), 32'd18);
      chk("held pulses", 32'(pulses), 32'd3);
      chk("held diff", 32'(Diff), 32'h20);
      for (int i = 0; i < 12; i++) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
